regfile_mp: RTL

Parametrised multi-port integer register file with an integrated pending-write scoreboard. It is the next-generation replacement for the single-write, dual-read RV32 register file. It sits between decode/issue, which reads operands and reserves destinations, and writeback, which has one or more retire lanes. Register 0 is hard-wired to zero, and the block exposes per-operand busy flags so issue can stall on RAW and WAW hazards.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 75 +++++++
 rtl/regfile_mp.sv | 84 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 register-file types and default sizing.
// The optional write-to-read forwarding is selected by REGFILE_BYPASS_EN
// in the files that use this package.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for regfile_mp.
// Tracks one pending bit per register, resolves set/clear collisions in
// favour of the new reservation, and answers busy/ready lookups.
// REGFILE_BYPASS_EN: a write landing this cycle counts as already cleared
// for busy and ready lookups.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy,
    output logic              iss_ready
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] clr_now;
    logic [NREGS-1:0] set_now;

    // Decode this cycle's clears (any lane write) and set (reservation); x0 never tracked.
    always_comb begin
        clr_now = '0;
        set_now = '0;
        for (int j = 0; j < NWR; j++) begin
            if (we[j]) begin
                clr_now[wa[j*AW +: AW]] = 1'b1;
            end
        end
        if (iss_valid) begin
            set_now[iss_rd] = 1'b1;
        end
        clr_now[0] = 1'b0;
        set_now[0] = 1'b0;
        // A reservation belongs to a newer instruction than any retiring write.
        pending_d = set_now | (pending_q & ~clr_now);
    end

    // Pending vector register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Per-port busy lookup and destination-free indication.
    always_comb begin
        rs_busy = '0;
        for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_BYPASS_EN
            rs_busy[k] = pending_q[rs_addr[k*AW +: AW]]
                       & ~(clr_now[rs_addr[k*AW +: AW]] & ~set_now[rs_addr[k*AW +: AW]]);
`else
            rs_busy[k] = pending_q[rs_addr[k*AW +: AW]];
`endif
        end
`ifdef REGFILE_BYPASS_EN
        iss_ready = ~pending_q[iss_rd] | clr_now[iss_rd];
`else
        iss_ready = ~pending_q[iss_rd];
`endif
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard.
// x0 reads as zero and ignores writes; on a same-address multi-lane write
// the highest-index lane wins.
// REGFILE_BYPASS_EN: same-cycle writes are forwarded to the read ports.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Register array: lanes applied in index order so the youngest lane lands last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] != '0)) begin
                    regs_q[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rs_addr[gi*AW +: AW];

        // Read mux for one port; x0 always returns zero.
        always_comb begin
            data = '0;
            if (addr != '0) begin
                data = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j*AW +: AW] == addr)) begin
                        data = wd[j*XLEN +: XLEN];
                    end
                end
`endif
            end
        end

        assign rs_data[gi*XLEN +: XLEN] = data;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs_addr   (rs_addr),
        .rs_busy   (rs_busy),
        .iss_ready (iss_ready)
    );

endmodule
